// File: rtl/obuft_tx_sequencer_if.sv
// Word stream into the tri-state pad sequencer (valid/ready handshake).
// The master is the word source; the slave is the sequencer.
interface obuft_tx_sequencer_if #(
    parameter int DATA_W = 16
) ();
    logic              S_VALID;
    logic              S_READY;
    logic [DATA_W-1:0] S_DATA;
    logic              S_LAST;

    modport master (
        output S_VALID,
        output S_DATA,
        output S_LAST,
        input  S_READY
    );

    modport slave (
        input  S_VALID,
        input  S_DATA,
        input  S_LAST,
        output S_READY
    );
endinterface

// File: rtl/obuft_tx_sequencer.sv
// Serialises DATA_W-bit words onto a PAD_W-bit tri-state pad group.
// The bus is parked (driven low) for TURN_CYC lead-in cycles before a burst
// and released (high-Z) for TURN_CYC tail cycles after the burst's last word.
// All outputs come straight from flops, except PAD_T, which also ORs in GTS
// so the pads float immediately when global tri-state is asserted.
module obuft_tx_sequencer #(
    parameter int DATA_W   = 16,
    parameter int PAD_W    = 4,
    parameter int TURN_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   GTS,
    obuft_tx_sequencer_if.slave    s_if,
    output logic [PAD_W-1:0]       PAD_I,
    output logic [PAD_W-1:0]       PAD_T,
    output logic                   BUSY
);
    localparam int BEATS  = DATA_W / PAD_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TAIL  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          turn_q, turn_d;
    logic [PAD_W-1:0]    pad_i_q, pad_i_d;
    logic [PAD_W-1:0]    t_q, t_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                accept_s;

    assign accept_s    = s_if.S_VALID & ready_q;
    assign s_if.S_READY = ready_q;
    assign PAD_I       = pad_i_q;
    assign PAD_T       = t_q | {PAD_W{GTS}};
    assign BUSY        = busy_q;

    // State register: every flop of the block, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            data_q  <= {DATA_W{1'b0}};
            last_q  <= 1'b0;
            beat_q  <= {BEAT_W{1'b0}};
            turn_q  <= 4'd0;
            pad_i_q <= {PAD_W{1'b0}};
            t_q     <= {PAD_W{1'b1}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            turn_q  <= turn_d;
            pad_i_q <= pad_i_d;
            t_q     <= t_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: sequencing, word capture, beat and turnaround counting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        beat_d  = beat_q;
        turn_d  = turn_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d = s_if.S_DATA;
                    last_d = s_if.S_LAST;
                    beat_d = {BEAT_W{1'b0}};
                    if (TURN_CYC == 0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_LEAD;
                        turn_d  = TURN_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (turn_q == 4'd0) begin
                    state_d = ST_SHIFT;
                    beat_d  = {BEAT_W{1'b0}};
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            ST_SHIFT: begin
                if (beat_q == LAST_BEAT) begin
                    beat_d = {BEAT_W{1'b0}};
                    if (accept_s) begin
                        // Ready is only offered on a non-last final beat, so
                        // the next word follows with no gap.
                        data_d  = s_if.S_DATA;
                        last_d  = s_if.S_LAST;
                        state_d = ST_SHIFT;
                    end else if (last_q) begin
                        if (TURN_CYC == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_TAIL;
                            turn_d  = TURN_LOAD;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    data_d  = s_if.S_DATA;
                    last_d  = s_if.S_LAST;
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_TAIL: begin
                if (turn_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered pads,
    // T, ready and busy line up with the state they describe.
    always_comb begin
        pad_i_d = {PAD_W{1'b0}};
        t_d     = {PAD_W{1'b1}};
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_LEAD: begin
                t_d = {PAD_W{1'b0}};
            end
            ST_SHIFT: begin
                t_d     = {PAD_W{1'b0}};
                pad_i_d = data_d[int'(beat_d) * PAD_W +: PAD_W];
                ready_d = (beat_d == LAST_BEAT) && !last_d;
            end
            ST_HOLD: begin
                t_d     = {PAD_W{1'b0}};
                ready_d = 1'b1;
            end
            ST_TAIL: begin
                t_d = {PAD_W{1'b1}};
            end
            default: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_obuft_tx_sequencer.sv
// Directed bench for obuft_tx_sequencer: per-cycle expected pad records are
// pushed to a scoreboard queue as stimulus is planned and popped after each
// clock edge.
module tb_obuft_tx_sequencer;
    localparam int DATA_W = 16;
    localparam int PAD_W  = 4;
    localparam int TURN   = 2;

    typedef struct packed {
        logic [3:0] i;
        logic [3:0] t;
        logic       rdy;
        logic       busy;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             gts;
    logic [PAD_W-1:0] pad_i;
    logic [PAD_W-1:0] pad_t;
    logic             busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    obuft_tx_sequencer_if #(.DATA_W(DATA_W)) sif ();

    obuft_tx_sequencer #(
        .DATA_W  (DATA_W),
        .PAD_W   (PAD_W),
        .TURN_CYC(TURN)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .GTS  (gts),
        .s_if (sif),
        .PAD_I(pad_i),
        .PAD_T(pad_t),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] i, input logic [3:0] t, input logic rdy, input logic bsy);
        exp_t e;
        e.i = i; e.t = t; e.rdy = rdy; e.busy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic push_lead();
        for (int k = 0; k < TURN; k++) push(4'h0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic push_tail();
        for (int k = 0; k < TURN; k++) push(4'h0, 4'hF, 1'b0, 1'b1);
    endtask

    task automatic push_idle();
        push(4'h0, 4'hF, 1'b1, 1'b0);
    endtask

    // Beats least-significant first; ready only on the final beat of a non-last word.
    task automatic push_beats(input logic [15:0] w, input logic last);
        for (int k = 0; k < 4; k++)
            push(w[k*4 +: 4], 4'h0, (k == 3) && !last, 1'b1);
    endtask

    // Drive inputs, take one clock edge, compare against the next scoreboard record.
    task automatic tick(input logic vld, input logic [15:0] data, input logic last, input logic g);
        exp_t e;
        sif.S_VALID = vld;
        sif.S_DATA  = data;
        sif.S_LAST  = last;
        gts         = g;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty cycle=%0d observed=0 expected=1", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("pad_i", {12'h000, pad_i}, {12'h000, e.i});
            chk("pad_t", {12'h000, pad_t}, {12'h000, e.t | {4{gts}}});
            chk("s_ready", {15'h0000, sif.S_READY}, {15'h0000, e.rdy});
            chk("busy", {15'h0000, busy}, {15'h0000, e.busy});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        gts         = 1'b0;
        sif.S_VALID = 1'b0;
        sif.S_DATA  = 16'h0000;
        sif.S_LAST  = 1'b0;

        // Reset held three cycles: bus released, not ready
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pad_t", {12'h000, pad_t}, 16'h000F);
        chk("rst_pad_i", {12'h000, pad_i}, 16'h0000);
        chk("rst_busy", {15'h0000, busy}, 16'h0000);
        chk("rst_ready", {15'h0000, sif.S_READY}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle();
        tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // Single last word: lead, 4 beats, tail, idle
        push_lead(); push_beats(16'hA5C3, 1'b1); push_tail(); push_idle();
        tick(1'b1, 16'hA5C3, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // Back-to-back words with no gap
        push_lead(); push_beats(16'h1234, 1'b0); push_beats(16'hBEEF, 1'b1);
        push_tail(); push_idle();
        tick(1'b1, 16'h1234, 1'b0, 1'b0);
        repeat (6) tick(1'b1, 16'hBEEF, 1'b1, 1'b0);
        repeat (6) tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // Hold: bus parked and ready, then resume without lead-in
        push_lead(); push_beats(16'h00FF, 1'b0);
        for (int k = 0; k < 5; k++) push(4'h0, 4'h0, 1'b1, 1'b1);
        push_beats(16'h9876, 1'b1); push_tail(); push_idle();
        tick(1'b1, 16'h00FF, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 16'h0000, 1'b0, 1'b0);
        tick(1'b1, 16'h9876, 1'b1, 1'b0);
        repeat (6) tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // GTS mid-word: immediate float, sequencing unaffected
        push_lead(); push_beats(16'hA5C3, 1'b1); push_tail(); push_idle();
        tick(1'b1, 16'hA5C3, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 16'h0000, 1'b0, 1'b0);
        gts = 1'b1;
        #1;
        chk("gts_pad_t", {12'h000, pad_t}, 16'h000F);
        chk("gts_pad_i", {12'h000, pad_i}, 16'h000C);
        tick(1'b0, 16'h0000, 1'b0, 1'b1);
        tick(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // Async reset during beat 1: outputs clear with no edge, no beats afterwards
        push_lead();
        push(4'h3, 4'h0, 1'b0, 1'b1);
        push(4'hC, 4'h0, 1'b0, 1'b1);
        tick(1'b1, 16'hA5C3, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 16'h0000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pad_t", {12'h000, pad_t}, 16'h000F);
        chk("arst_pad_i", {12'h000, pad_i}, 16'h0000);
        chk("arst_busy", {15'h0000, busy}, 16'h0000);
        chk("arst_ready", {15'h0000, sif.S_READY}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push_idle();
        repeat (4) tick(1'b0, 16'h0000, 1'b0, 1'b0);

        chk("sb_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
